// File: rtl/mmu_responder.sv
// mmu_responder: memory-side responder for the CPU mem_if master port.
// Owns WRAM (C000-DFFF, echoed at E000-FDFF), HRAM (FF80-FFFE), IF (FF0F), IE (FFFF)
// and the OAM DMA engine (FF46). Every other address is forwarded to the external bus.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   addr_select/write_value/write_enable   CPU access (write strobe is level per clock)
//   read_out                     registered read data, 1 clock after the address
//   irq_req                      per-source interrupt request pulses into IF
//   mmio_reg_IF, mmio_reg_IE     live interrupt registers back to the CPU
//   ext_addr/ext_wdata/ext_we/ext_rdata   external bus (ext_rdata combinational)
//   oam_we/oam_addr/oam_wdata    OAM write port driven by the DMA engine
//   dma_active                   high while DMA is in START or COPY
module mmu_responder #(
  parameter int unsigned WRAM_BYTES        = 8192,
  parameter int unsigned DMA_LEN           = 160,
  parameter int unsigned DMA_CLKS_PER_BYTE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_select,
  input  logic [7:0]  write_value,
  input  logic        write_enable,
  output logic [7:0]  read_out,
  input  logic [4:0]  irq_req,
  output logic [7:0]  mmio_reg_IF,
  output logic [7:0]  mmio_reg_IE,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  output logic        ext_we,
  input  logic [7:0]  ext_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  localparam int unsigned WA = $clog2(WRAM_BYTES);
  localparam int unsigned SW = (DMA_CLKS_PER_BYTE > 1) ? $clog2(DMA_CLKS_PER_BYTE) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StCopy  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    src_q, src_d;
  logic [7:0]    ie_q, ie_d;
  logic [4:0]    if_q, if_d;
  logic [7:0]    rd_q, rd_d;

  logic [7:0] wram_q [WRAM_BYTES];
  logic [7:0] hram_q [128];

  // Address decode
  logic hi_page, is_wram, is_hram, is_if, is_ie, is_dma, is_ext;
  assign hi_page = (addr_select[15:8] == 8'hFF);
  assign is_wram = (addr_select >= 16'hC000) && (addr_select <= 16'hFDFF);
  assign is_hram = hi_page && addr_select[7] && (addr_select != 16'hFFFF);
  assign is_if   = (addr_select == 16'hFF0F);
  assign is_ie   = (addr_select == 16'hFFFF);
  assign is_dma  = (addr_select == 16'hFF46);
  assign is_ext  = !(is_wram || is_hram || is_if || is_ie || is_dma);

  // DMA datapath
  logic        sub_last, dma_beat, dma_bus, src_wram, restart;
  logic [7:0]  eff_hi, dma_rdata;
  logic [15:0] dma_addr;

  assign dma_active = (state_q != StIdle);
  assign sub_last   = (sub_q == SW'(DMA_CLKS_PER_BYTE - 1));
  // Sources at E0 and above alias onto the WRAM echo region.
  assign eff_hi     = (src_q >= 8'hE0) ? (src_q & 8'hDF) : src_q;
  assign src_wram   = (eff_hi[7:5] == 3'b110);
  assign dma_addr   = {eff_hi, cnt_q};
  assign dma_beat   = (state_q == StCopy) && sub_last;
  // The external bus is only claimed on the fetch clock of an external-source byte.
  assign dma_bus    = dma_beat && !src_wram;
  assign dma_rdata  = src_wram ? wram_q[dma_addr[WA-1:0]] : ext_rdata;
  assign restart    = write_enable && is_dma;

  // While DMA runs the CPU only sees the FF page.
  logic cpu_blocked, cpu_we;
  assign cpu_blocked = dma_active && !hi_page;
  assign cpu_we      = write_enable && !cpu_blocked;

  assign ext_addr  = dma_bus ? dma_addr : addr_select;
  assign ext_wdata = write_value;
  assign ext_we    = cpu_we && is_ext && !dma_bus;

  // A restart on the fetch clock cancels that byte.
  assign oam_we    = dma_beat && !restart;
  assign oam_addr  = cnt_q;
  assign oam_wdata = dma_rdata;

  assign read_out    = rd_q;
  assign mmio_reg_IF = {3'b000, if_q};
  assign mmio_reg_IE = ie_q;

  // Read mux samples current contents, so a same-clock write reads back the old value.
  always_comb begin
    rd_d = 8'hFF;
    if (cpu_blocked) begin
      rd_d = 8'hFF;
    end else if (is_wram) begin
      rd_d = wram_q[addr_select[WA-1:0]];
    end else if (is_hram) begin
      rd_d = hram_q[addr_select[6:0]];
    end else if (is_if) begin
      rd_d = {3'b111, if_q};
    end else if (is_ie) begin
      rd_d = ie_q;
    end else if (is_dma) begin
      rd_d = src_q;
    end else if (!dma_bus) begin
      rd_d = ext_rdata;
    end
  end

  always_comb begin
    ie_d = (cpu_we && is_ie) ? write_value : ie_q;
    if_d = ((cpu_we && is_if) ? write_value[4:0] : if_q) | irq_req;
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    if (restart) begin
      src_d   = write_value;
      state_d = StStart;
      sub_d   = '0;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        StStart: begin
          if (sub_last) begin
            state_d = StCopy;
            sub_d   = '0;
            cnt_d   = 8'd0;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
        StCopy: begin
          if (sub_last) begin
            sub_d = '0;
            if (cnt_q == 8'(DMA_LEN - 1)) begin
              state_d = StIdle;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sub_q   <= '0;
      cnt_q   <= 8'd0;
      src_q   <= 8'd0;
      ie_q    <= 8'd0;
      if_q    <= 5'd0;
      rd_q    <= 8'hFF;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      ie_q    <= ie_d;
      if_q    <= if_d;
      rd_q    <= rd_d;
    end
  end

  // Storage arrays carry no reset; contents are undefined after reset.
  always_ff @(posedge clk) begin
    if (cpu_we && is_wram) wram_q[addr_select[WA-1:0]] <= write_value;
    if (cpu_we && is_hram) hram_q[addr_select[6:0]] <= write_value;
  end

endmodule

// File: tb/tb_mmu_responder.sv
module tb_mmu_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr_select = 16'h0000;
  logic [7:0]  write_value = 8'h00;
  logic        write_enable = 1'b0;
  logic [7:0]  read_out;
  logic [4:0]  irq_req = 5'd0;
  logic [7:0]  mmio_reg_IF, mmio_reg_IE;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_we;
  logic [7:0]  ext_rdata;
  logic        oam_we;
  logic [7:0]  oam_addr, oam_wdata;
  logic        dma_active;

  int checks = 0;
  int failures = 0;

  // External bus model: returns the low address byte.
  assign ext_rdata = ext_addr[7:0];

  always #5 clk = ~clk;

  mmu_responder dut (
    .clk          (clk),
    .rst          (rst),
    .addr_select  (addr_select),
    .write_value  (write_value),
    .write_enable (write_enable),
    .read_out     (read_out),
    .irq_req      (irq_req),
    .mmio_reg_IF  (mmio_reg_IF),
    .mmio_reg_IE  (mmio_reg_IE),
    .ext_addr     (ext_addr),
    .ext_wdata    (ext_wdata),
    .ext_we       (ext_we),
    .ext_rdata    (ext_rdata),
    .oam_we       (oam_we),
    .oam_addr     (oam_addr),
    .oam_wdata    (oam_wdata),
    .dma_active   (dma_active)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] v, input logic we);
    addr_select  = a;
    write_value  = v;
    write_enable = we;
  endtask

  // Samples from the clock after the FF46 write edge onward.
  task automatic run_dma(input bit ext_src, output int active, output int pulses,
                         output int errs);
    logic [7:0] k;
    active = 0;
    pulses = 0;
    errs   = 0;
    for (int i = 0; i < 700; i++) begin
      if (dma_active) active++;
      if (oam_we) begin
        k = 8'(pulses);
        if (oam_addr !== k) errs++;
        if (ext_src) begin
          if (oam_wdata !== k) errs++;
          if (ext_addr !== {8'h40, k}) errs++;
          if (ext_we !== 1'b0) errs++;
        end else begin
          if (oam_wdata !== (k ^ 8'h3C)) errs++;
        end
        pulses++;
      end
      step();
    end
  endtask

  int active, pulses, errs;
  bit ok;

  initial begin
    // Reset state
    #3 rst = 1'b1;
    #2;
    chk("rst_read_out", read_out, 8'hFF);
    chk("rst_dma_active", dma_active, 1'b0);
    chk("rst_oam_we", oam_we, 1'b0);
    chk("rst_if", mmio_reg_IF, 8'h00);
    chk("rst_ie", mmio_reg_IE, 8'h00);
    step();
    step();
    rst = 1'b0;
    step();

    // WRAM, echo and read-before-write
    drive(16'hC123, 8'hA5, 1'b1); step();
    drive(16'hC123, 8'h00, 1'b0); step();
    chk("wram_read", read_out, 8'hA5);
    drive(16'hE123, 8'h00, 1'b0); step();
    chk("wram_echo_read", read_out, 8'hA5);
    drive(16'hE123, 8'h5A, 1'b1); step();
    chk("read_before_write", read_out, 8'hA5);
    drive(16'hC123, 8'h00, 1'b0); step();
    chk("echo_write_read", read_out, 8'h5A);

    // HRAM
    drive(16'hFF80, 8'h11, 1'b1); step();
    drive(16'hFFFE, 8'h22, 1'b1); step();
    drive(16'hFF80, 8'h00, 1'b0); step();
    chk("hram_ff80", read_out, 8'h11);
    drive(16'hFFFE, 8'h00, 1'b0); step();
    chk("hram_fffe", read_out, 8'h22);

    // IF / IE
    irq_req = 5'b00100; step();
    irq_req = 5'b00000;
    chk("if_irq", mmio_reg_IF, 8'h04);
    drive(16'hFF0F, 8'h00, 1'b1); irq_req = 5'b00001; step();
    irq_req = 5'b00000;
    chk("if_write_irq", mmio_reg_IF, 8'h01);
    drive(16'hFF0F, 8'h00, 1'b0); step();
    chk("if_read", read_out, 8'hE1);
    drive(16'hFFFF, 8'h9B, 1'b1); step();
    chk("ie_reg", mmio_reg_IE, 8'h9B);
    drive(16'hFFFF, 8'h00, 1'b0); step();
    chk("ie_read", read_out, 8'h9B);

    // External bus
    drive(16'h4123, 8'h00, 1'b0); step();
    chk("ext_read", read_out, 8'h23);
    drive(16'h8000, 8'h77, 1'b1); #1;
    chk("ext_we_ext", ext_we, 1'b1);
    drive(16'hC000, 8'h77, 1'b1); #1;
    chk("ext_we_wram", ext_we, 1'b0);
    drive(16'h0000, 8'h00, 1'b0); step();

    // WRAM-source DMA
    for (int i = 0; i < 160; i++) begin
      drive(16'hC000 + 16'(i), 8'(i) ^ 8'h3C, 1'b1);
      step();
    end
    drive(16'hFF46, 8'hC0, 1'b1); step();
    drive(16'h0000, 8'h00, 1'b0);
    run_dma(1'b0, active, pulses, errs);
    chk("dma_active_clks", active, 644);
    chk("dma_pulses", pulses, 160);
    chk("dma_seq_errs", errs, 0);

    // Bus lock during DMA
    drive(16'hFF46, 8'hC0, 1'b1); step();
    drive(16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) step();
    drive(16'hC000, 8'h00, 1'b0); step();
    chk("lock_read_c000", read_out, 8'hFF);
    drive(16'hFF90, 8'h5A, 1'b1); step();
    drive(16'hFF90, 8'h00, 1'b0); step();
    chk("lock_hram_rw", read_out, 8'h5A);
    drive(16'hFF46, 8'h00, 1'b0); step();
    chk("ff46_readback", read_out, 8'hC0);
    drive(16'hC000, 8'h77, 1'b1); step();
    drive(16'h0000, 8'h00, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 800 && !ok; i++) begin
      if (!dma_active) ok = 1'b1;
      else step();
    end
    chk("dma_end_timeout", ok, 1'b1);
    drive(16'hC000, 8'h00, 1'b0); step();
    chk("lock_write_dropped", read_out, 8'h3C);

    // External-source DMA
    drive(16'hFF46, 8'h40, 1'b1); step();
    drive(16'h0000, 8'h00, 1'b0);
    run_dma(1'b1, active, pulses, errs);
    chk("ext_dma_pulses", pulses, 160);
    chk("ext_dma_errs", errs, 0);
    chk("ext_dma_active", active, 644);

    // Reset mid-DMA
    drive(16'hFF46, 8'hC0, 1'b1); step();
    drive(16'h0000, 8'h00, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (oam_we && oam_addr == 8'd50) ok = 1'b1;
      else step();
    end
    chk("wait_byte50", ok, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_oam_we", oam_we, 1'b0);
    chk("mid_rst_dma_active", dma_active, 1'b0);
    chk("mid_rst_read_out", read_out, 8'hFF);
    chk("mid_rst_ie", mmio_reg_IE, 8'h00);
    chk("mid_rst_if", mmio_reg_IF, 8'h00);
    chk("mid_rst_ext_we", ext_we, 1'b0);
    step();
    step();
    rst = 1'b0;
    run_dma(1'b0, active, pulses, errs);
    chk("post_rst_pulses", pulses, 0);
    chk("post_rst_active", active, 0);

    // Fresh transfer starts at OAM index 0
    drive(16'hFF46, 8'hC0, 1'b1); step();
    drive(16'h0000, 8'h00, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (oam_we) ok = 1'b1;
      else step();
    end
    chk("fresh_first_pulse", ok, 1'b1);
    chk("fresh_oam_addr", oam_addr, 8'd0);
    chk("fresh_oam_wdata", oam_wdata, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
